// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StMdBusy   = 2'd1,
    StExcFlush = 2'd2
  } state_e;

  localparam int unsigned MulLatDefault = 4;
  localparam int unsigned DivLatDefault = 33;
  localparam logic [4:0]  RegZero       = 5'd0;

endpackage

// File: rtl/pipe_md_timer.sv
// Down-counter that tracks how long a mul/div still occupies EX.
module pipe_md_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             abort,
  output logic             zero,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (!rset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      cnt_q  <= load_val;
      busy_q <= 1'b1;
    end else if (dec) begin
      // A decrement at zero is the final cycle: the operation retires.
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign zero = (cnt_q == '0);
  assign busy = busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional stall counter enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MulLatDefault,
  parameter int unsigned DIV_LAT = DivLatDefault,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rset,
  input  logic        if_wait,
  input  logic        mem_wait,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rt,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  input  logic        exc_req,
  output logic        pc_en,
  output logic        if_id_adv,
  output logic        id_ex_adv,
  output logic        ex_mem_adv,
  output logic        mem_wb_adv,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] perf_stall_cnt
);

  state_e           state_q, state_d;
  logic             md_load, md_dec, md_abort, md_start_cyc;
  logic             md_zero, md_tmr_busy;
  logic [CNT_W-1:0] md_load_val;
  logic             load_use;

  assign md_load_val = ex_md_is_div ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);

  assign load_use = ex_is_load && (ex_rt != RegZero) &&
                    ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));

  pipe_md_timer #(
    .CNT_W (CNT_W)
  ) u_md_timer (
    .clk      (clk),
    .rset     (rset),
    .load     (md_load),
    .load_val (md_load_val),
    .dec      (md_dec),
    .abort    (md_abort),
    .zero     (md_zero),
    .busy     (md_tmr_busy)
  );

  always_ff @(posedge clk) begin
    if (!rset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    if_id_adv    = 1'b0;
    id_ex_adv    = 1'b0;
    ex_mem_adv   = 1'b0;
    mem_wb_adv   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_done      = 1'b0;
    md_load      = 1'b0;
    md_dec       = 1'b0;
    md_abort     = 1'b0;
    md_start_cyc = 1'b0;

    if (!rset || mem_wait) begin
      // Everything holds; state and counter stay frozen.
    end else if (exc_req) begin
      pc_en        = 1'b1;
      if_id_adv    = 1'b1;
      id_ex_adv    = 1'b1;
      ex_mem_adv   = 1'b1;
      mem_wb_adv   = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      md_abort     = 1'b1;
      state_d      = StExcFlush;
    end else if (state_q == StExcFlush) begin
      pc_en       = 1'b1;
      if_id_adv   = 1'b1;
      id_ex_adv   = 1'b1;
      ex_mem_adv  = 1'b1;
      mem_wb_adv  = 1'b1;
      if_id_flush = 1'b1;
      state_d     = StRun;
    end else if (state_q == StMdBusy || ex_md_start) begin
      md_dec = (state_q == StMdBusy);
      if (state_q == StMdBusy && md_zero) begin
        // Final EX cycle; ex_md_start still belongs to this same instruction.
        pc_en      = 1'b1;
        if_id_adv  = 1'b1;
        id_ex_adv  = 1'b1;
        ex_mem_adv = 1'b1;
        mem_wb_adv = 1'b1;
        md_done    = 1'b1;
        state_d    = StRun;
      end else begin
        // Hold IF/ID/EX, push a bubble out of EX while MEM/WB drain.
        ex_mem_adv   = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_adv   = 1'b1;
        if (state_q == StRun) begin
          md_load      = 1'b1;
          md_start_cyc = 1'b1;
          state_d      = StMdBusy;
        end
      end
    end else if (if_wait) begin
      if_id_adv   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_adv   = 1'b1;
      ex_mem_adv  = 1'b1;
      mem_wb_adv  = 1'b1;
    end else if (load_use) begin
      id_ex_adv   = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_adv  = 1'b1;
      mem_wb_adv  = 1'b1;
    end else begin
      pc_en      = 1'b1;
      if_id_adv  = 1'b1;
      id_ex_adv  = 1'b1;
      ex_mem_adv = 1'b1;
      mem_wb_adv = 1'b1;
    end
  end

  // The timer's busy flag mirrors the MD_BUSY state.
  assign md_busy = rset && (md_start_cyc || md_tmr_busy);

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rset) begin
      perf_q <= '0;
    end else if (!pc_en) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default MUL_LAT=4, DIV_LAT=33).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rset;
  logic        if_wait, mem_wait;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_use_rs, id_use_rt, ex_is_load;
  logic        ex_md_start, ex_md_is_div, exc_req;
  logic        pc_en, if_id_adv, id_ex_adv, ex_mem_adv, mem_wb_adv;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_done;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  // {pc_en, if_id/id_ex/ex_mem/mem_wb adv, if_id/id_ex/ex_mem flush, md_busy, md_done}
  logic [9:0] obs;
  assign obs = {pc_en, if_id_adv, id_ex_adv, ex_mem_adv, mem_wb_adv,
                if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_done};

  localparam logic [9:0] P_ZERO  = 10'b00000_000_00;
  localparam logic [9:0] P_NORM  = 10'b11111_000_00;
  localparam logic [9:0] P_LU    = 10'b00111_010_00;
  localparam logic [9:0] P_IFW   = 10'b01111_100_00;
  localparam logic [9:0] P_MDST  = 10'b00011_001_10;
  localparam logic [9:0] P_MDDN  = 10'b11111_000_11;
  localparam logic [9:0] P_EXC   = 10'b11111_111_00;
  localparam logic [9:0] P_EXCMD = 10'b11111_111_10;
  localparam logic [9:0] P_EXCFL = 10'b11111_100_00;
  localparam logic [9:0] P_MWMD  = 10'b00000_000_10;

  pipe_hazard_ctrl u_dut (
    .clk            (clk),
    .rset           (rset),
    .if_wait        (if_wait),
    .mem_wait       (mem_wait),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .ex_is_load     (ex_is_load),
    .ex_rt          (ex_rt),
    .ex_md_start    (ex_md_start),
    .ex_md_is_div   (ex_md_is_div),
    .exc_req        (exc_req),
    .pc_en          (pc_en),
    .if_id_adv      (if_id_adv),
    .id_ex_adv      (id_ex_adv),
    .ex_mem_adv     (ex_mem_adv),
    .mem_wb_adv     (mem_wb_adv),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_flush   (ex_mem_flush),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_wait = 0; mem_wait = 0; exc_req = 0;
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 0; id_use_rt = 0;
    ex_is_load = 0; ex_rt = 5'd0; ex_md_start = 0; ex_md_is_div = 0;
  endtask

  task automatic test_reset();
    rset = 0;
    idle_inputs();
    exc_req = 1; ex_md_start = 1; if_wait = 1;
    @(negedge clk);
    checks++;
    if (obs !== P_ZERO) begin
      errors++; $display("FAIL reset_outputs got=%b want=%b", obs, P_ZERO);
    end
    tick();
    @(negedge clk);
    checks++;
    if (perf_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_perf got=%0d want=0", perf_stall_cnt);
    end
    tick();
    idle_inputs();
    rset = 1;
  endtask

  task automatic test_normal();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== P_NORM) begin
        errors++; $display("FAIL normal[%0d] got=%b want=%b", i, obs, P_NORM);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [9:0] want [5];
    want = '{P_LU, P_NORM, P_LU, P_NORM, P_NORM};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      case (i)
        0: begin ex_is_load = 1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1; end
        1: begin id_rs = 5'd8; id_use_rs = 1; end  // load has moved on
        2: begin ex_is_load = 1; ex_rt = 5'd3; id_rt = 5'd3; id_use_rt = 1; end
        3: begin ex_is_load = 1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1; end
        default: begin ex_is_load = 1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 0; end
      endcase
      @(negedge clk);
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs, want[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_if_wait();
    idle_inputs();
    if_wait = 1;
    @(negedge clk);
    checks++;
    if (obs !== P_IFW) begin
      errors++; $display("FAIL if_wait got=%b want=%b", obs, P_IFW);
    end
    tick();
    ex_is_load = 1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    @(negedge clk);
    checks++;
    if (obs !== P_IFW) begin
      errors++; $display("FAIL if_wait_over_lu got=%b want=%b", obs, P_IFW);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_multiply();
    logic [9:0] want [5];
    want = '{P_MDST, P_MDST, P_MDST, P_MDDN, P_NORM};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      ex_md_start = (i < 4);
      @(negedge clk);
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL mul_cycle[%0d] got=%b want=%b", i + 1, obs, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_divide_abort();
    for (int i = 1; i <= 12; i++) begin
      idle_inputs();
      ex_md_start  = (i <= 10);
      ex_md_is_div = 1;
      exc_req      = (i == 10);
      @(negedge clk);
      checks++;
      if (i < 10 && obs !== P_MDST) begin
        errors++; $display("FAIL div_stall[%0d] got=%b want=%b", i, obs, P_MDST);
      end else if (i == 10 && obs !== P_EXCMD) begin
        errors++; $display("FAIL div_exc got=%b want=%b", obs, P_EXCMD);
      end else if (i == 11 && obs !== P_EXCFL) begin
        errors++; $display("FAIL div_excflush got=%b want=%b", obs, P_EXCFL);
      end else if (i == 12 && obs !== P_NORM) begin
        errors++; $display("FAIL div_after got=%b want=%b", obs, P_NORM);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait_md();
    logic [9:0] want [10];
    want = '{P_MDST, P_MDST, P_MWMD, P_MWMD, P_MWMD, P_MWMD, P_MWMD,
             P_MDST, P_MDDN, P_NORM};
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      ex_md_start = (i < 9);
      mem_wait    = (i >= 2 && i < 7);
      @(negedge clk);
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL mw_md[%0d] got=%b want=%b", i, obs, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait_exc();
    logic [9:0] want [5];
    want = '{P_ZERO, P_ZERO, P_EXC, P_EXCFL, P_NORM};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      mem_wait = (i < 2);
      exc_req  = (i < 3);
      @(negedge clk);
      checks++;
      if (obs !== want[i]) begin
        errors++; $display("FAIL mw_exc[%0d] got=%b want=%b", i, obs, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_div();
    idle_inputs();
    ex_md_start = 1; ex_md_is_div = 1;
    for (int i = 0; i < 4; i++) tick();
    rset = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== P_ZERO || perf_stall_cnt !== 32'd0) begin
        errors++;
        $display("FAIL rst_mid_div[%0d] got=%b/%0d want=%b/0", i, obs, perf_stall_cnt, P_ZERO);
      end
      tick();
    end
    rset = 1;
    idle_inputs();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== P_NORM) begin
        errors++; $display("FAIL after_rst[%0d] got=%b want=%b", i, obs, P_NORM);
      end
      tick();
    end
  endtask

  initial begin
    rset = 0;
    idle_inputs();
    test_reset();
    test_normal();
    test_load_use();
    test_if_wait();
    test_multiply();
    test_divide_abort();
    test_mem_wait_md();
    test_mem_wait_exc();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the PC enable plus per-register advance and flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB. Sources it arbitrates:
- instruction and data memory wait
- multi-cycle mul/div occupancy of EX
- load-use hazards
- exception redirect

Parameters:
MUL_LAT, 4, total EX-occupancy cycles of a multiply (>=2)
DIV_LAT, 33, total EX-occupancy cycles of a divide (>=2)
CNT_W, 6, width of the MD cycle counter (must hold DIV_LAT-2)

Ports:
clk  in  1  single clock
rset  in  1  reset, synchronous, active-low
if_wait  in  1  instruction memory not ready
mem_wait  in  1  data memory not ready
id_rs, id_rt  in  5  source registers of instruction in ID
id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt
ex_is_load  in  1  instruction in EX is a load
ex_rt  in  5  load destination register in EX
ex_md_start  in  1  mul/div instruction present in EX
ex_md_is_div  in  1  1 = divide, 0 = multiply
exc_req  in  1  exception/redirect raised at MEM
pc_en  out  1  PC register load enable
if_id_adv, id_ex_adv, ex_mem_adv, mem_wb_adv  out  1  stage register load (1 = capture input, 0 = hold)
if_id_flush, id_ex_flush, ex_mem_flush  out  1  load bubble (zeros) into register
md_busy  out  1  mul/div sequencing in progress
md_done  out  1  one-cycle pulse on final MD cycle
perf_stall_cnt  out  32  stall-cycle counter (optional feature)

Behaviour:
- Reset: synchronous, active-low, on rising clk.
  - State <= RUN, counter <= 0.
  - While rset=0 all outputs are forced 0: pc_en, all *_adv, all *_flush, md_busy, md_done.
  - Reset mid-MD aborts the operation; no md_done is issued.
- States: RUN, MD_BUSY, EXC_FLUSH. Outputs are combinational from state and inputs; transitions are registered.
- Flush rule: flush=1 forces the matching adv=1 so the bubble is captured.
- Priority per cycle, highest first:
  1. mem_wait: all adv=0, pc_en=0, no flush, state and counter frozen. exc_req is ignored this cycle.
  2. exc_req: pc_en=1; all adv=1; if_id_flush=id_ex_flush=ex_mem_flush=1. MD is aborted (md_done=0). Next state = EXC_FLUSH.
  3. EXC_FLUSH state: pc_en=1, if_id_flush=1 (kills the in-flight fetch), other stages advance. Next state = RUN.
  4. MD sequencing:
     - In RUN with ex_md_start=1: counter <= (div ? DIV_LAT : MUL_LAT) - 2; pc_en=if_id_adv=id_ex_adv=0; ex_mem_flush=1; mem_wb_adv=1; next state = MD_BUSY.
     - In MD_BUSY with counter != 0: same stall outputs; counter decrements.
     - In MD_BUSY with counter == 0: md_done=1; all advance normally; next state = RUN. ex_md_start is ignored in this cycle because it is the same instruction.
     - md_busy = (state == MD_BUSY) or the start cycle.
     - EX is held for exactly LAT cycles.
  5. if_wait: pc_en=0, if_id_flush=1 (bubble into ID). Downstream stages advance.
  6. Load-use, detected when ex_is_load and ex_rt != 0 and ((id_use_rs and id_rs == ex_rt) or (id_use_rt and id_rt == ex_rt)): pc_en=0, if_id_adv=0, id_ex_flush=1, EX/MEM and MEM/WB advance. This gives a single bubble.
  7. Otherwise: pc_en=1 and all adv=1.
- Lower-priority conditions in the same cycle are suppressed, not queued. Hazard inputs are re-evaluated every cycle.

Optional Feature:
- PIPE_PERF_CNT_EN defined: perf_stall_cnt increments (wrapping at 2^32) on every cycle with rset=1 and pc_en=0. It resets to 0.
- Not defined: perf_stall_cnt is tied to 0 and no counter register exists. The port list is unchanged.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding (RUN=2'd0, MD_BUSY=2'd1, EXC_FLUSH=2'd2)
  - default MUL_LAT/DIV_LAT constants
  - register-zero constant 5'd0
- One sub-module, pipe_md_timer:
  - Inputs: load, load value, decrement, abort.
  - Outputs: zero flag, busy.
  - Instantiated once for the MD counter.

Test Plan:
- Load-use: ex_is_load=1, ex_rt=5'd8, id_rs=8, id_use_rs=1 -> exactly one cycle with pc_en=0, if_id_adv=0, id_ex_flush=1. The same with ex_rt=0 -> no stall.
- Multiply: ex_md_start=1, ex_md_is_div=0, MUL_LAT=4 -> pc_en=0 for 3 cycles, md_done=1 on cycle 4, and ex_mem_flush=1 during cycles 1-3.
- Divide abort: start a divide, assert exc_req at cycle 10 -> three flushes that cycle, md_busy=0 next cycle, if_id_flush=1 in EXC_FLUSH, no md_done.
- mem_wait during MD_BUSY for 5 cycles -> all adv=0 and counter frozen; md_done is delayed by exactly 5 cycles.
- Simultaneous mem_wait and exc_req -> hold only. When mem_wait drops, the flush occurs that cycle.
- Reset asserted mid-divide -> next cycle all outputs 0. After release, ex_md_start=0 -> pc_en=1 and md_busy=0.
